decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_pkg.sv | 73 +++++++
 rtl/decode_queue_if.sv | 37 +++
 rtl/id_core.sv | 144 ++++++++++++++
 rtl/decode_queue.sv | 101 ++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode constants, instruction-type encodings and the stored control bundle.
package decode_queue_pkg;

    localparam int unsigned OPC_MSB = 6;
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_MSB  = 14;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_MSB = 24;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_MSB  = 31;
    localparam int unsigned F7_LSB  = 25;

    localparam logic [6:0] OP_RI     = 7'b0010011;
    localparam logic [6:0] OP_RR     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [5:0] {
        InstNop = 6'd0, InstLui, InstAuipc, InstJal, InstJalr,
        InstBeq, InstBne, InstBlt, InstBge, InstBltu, InstBgeu,
        InstLb, InstLh, InstLw, InstLbu, InstLhu, InstSb, InstSh, InstSw,
        InstAddi, InstSlti, InstSltiu, InstXori, InstOri, InstAndi,
        InstSlli, InstSrli, InstSrai,
        InstAdd, InstSub, InstSll, InstSlt, InstSltu, InstXor, InstSrl, InstSra,
        InstOr, InstAnd
    } inst_type_e;

    typedef struct packed {
        logic       illegal;
        inst_type_e inst_type;
        logic       rd_we;
        logic       rs1_read;
        logic       rs2_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_ctl_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side signals of the decode queue; slave is the queue side.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    logic                     in_valid_in;
    logic                     in_ready_out;
    logic [XLEN-1:0]          pc_in;
    logic [31:0]              inst_in;
    logic                     out_valid_out;
    logic                     out_ready_in;
    logic                     rs1_read_out;
    logic                     rs2_read_out;
    logic [4:0]               rs1_addr_out;
    logic [4:0]               rs2_addr_out;
    logic [4:0]               rd_addr_out;
    logic                     rd_we_out;
    logic [5:0]               inst_type_out;
    logic [XLEN-1:0]          imm_out;
    logic [XLEN-1:0]          pc_out;
    logic                     illegal_out;
    logic [$clog2(DEPTH):0]   count_out;

    modport slave (
        input  in_valid_in, pc_in, inst_in, out_ready_in,
        output in_ready_out, out_valid_out, rs1_read_out, rs2_read_out, rs1_addr_out,
               rs2_addr_out, rd_addr_out, rd_we_out, inst_type_out, imm_out, pc_out,
               illegal_out, count_out
    );

    modport master (
        output in_valid_in, pc_in, inst_in, out_ready_in,
        input  in_ready_out, out_valid_out, rs1_read_out, rs2_read_out, rs1_addr_out,
               rs2_addr_out, rd_addr_out, rd_we_out, inst_type_out, imm_out, pc_out,
               illegal_out, count_out
    );
endinterface

// File: rtl/id_core.sv
// Purely combinational RV32I decoder producing the bundle stored by decode_queue.
module id_core
    import decode_queue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    output dec_ctl_t        ctl_out,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] pc_out
);
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic        w_legal, w_rd_we, w_rs1_rd, w_rs2_rd;
    inst_type_e  w_type;
    logic [31:0] w_imm32;

    assign w_opcode = inst_in[OPC_MSB:OPC_LSB];
    assign w_f3     = inst_in[F3_MSB:F3_LSB];
    assign w_f7     = inst_in[F7_MSB:F7_LSB];
    assign w_imm_i  = {{20{inst_in[31]}}, inst_in[31:20]};
    assign w_imm_s  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
    assign w_imm_b  = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                       inst_in[11:8], 1'b0};
    assign w_imm_u  = {inst_in[31:12], 12'b0};
    assign w_imm_j  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                       inst_in[30:21], 1'b0};
    assign w_imm_sh = {27'b0, inst_in[24:20]};

    always_comb begin
        w_legal  = 1'b0;
        w_type   = InstNop;
        w_rd_we  = 1'b0;
        w_rs1_rd = 1'b0;
        w_rs2_rd = 1'b0;
        w_imm32  = '0;
        case (w_opcode)
            OP_LUI:   begin w_legal = 1'b1; w_type = InstLui;   w_rd_we = 1'b1; w_imm32 = w_imm_u; end
            OP_AUIPC: begin w_legal = 1'b1; w_type = InstAuipc; w_rd_we = 1'b1; w_imm32 = w_imm_u; end
            OP_JAL:   begin w_legal = 1'b1; w_type = InstJal;   w_rd_we = 1'b1; w_imm32 = w_imm_j; end
            OP_JALR: begin
                w_legal = (w_f3 == 3'b000);
                w_type  = InstJalr; w_rd_we = 1'b1; w_rs1_rd = 1'b1; w_imm32 = w_imm_i;
            end
            OP_BRANCH: begin
                w_legal = 1'b1; w_rs1_rd = 1'b1; w_rs2_rd = 1'b1; w_imm32 = w_imm_b;
                case (w_f3)
                    F3_BEQ:  w_type = InstBeq;
                    F3_BNE:  w_type = InstBne;
                    F3_BLT:  w_type = InstBlt;
                    F3_BGE:  w_type = InstBge;
                    F3_BLTU: w_type = InstBltu;
                    F3_BGEU: w_type = InstBgeu;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                w_legal = 1'b1; w_rd_we = 1'b1; w_rs1_rd = 1'b1; w_imm32 = w_imm_i;
                case (w_f3)
                    F3_B:    w_type = InstLb;
                    F3_H:    w_type = InstLh;
                    F3_W:    w_type = InstLw;
                    F3_BU:   w_type = InstLbu;
                    F3_HU:   w_type = InstLhu;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                w_legal = 1'b1; w_rs1_rd = 1'b1; w_rs2_rd = 1'b1; w_imm32 = w_imm_s;
                case (w_f3)
                    F3_B:    w_type = InstSb;
                    F3_H:    w_type = InstSh;
                    F3_W:    w_type = InstSw;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_RI: begin
                w_legal = 1'b1; w_rd_we = 1'b1; w_rs1_rd = 1'b1; w_imm32 = w_imm_i;
                case (w_f3)
                    F3_ADD:  w_type = InstAddi;
                    F3_SLT:  w_type = InstSlti;
                    F3_SLTU: w_type = InstSltiu;
                    F3_XOR:  w_type = InstXori;
                    F3_OR:   w_type = InstOri;
                    F3_AND:  w_type = InstAndi;
                    F3_SLL: begin
                        w_type = InstSlli; w_imm32 = w_imm_sh; w_legal = (w_f7 == F7_BASE);
                    end
                    default: begin
                        w_imm32 = w_imm_sh;
                        if (w_f7 == F7_BASE)     w_type  = InstSrli;
                        else if (w_f7 == F7_ALT) w_type  = InstSrai;
                        else                     w_legal = 1'b0;
                    end
                endcase
            end
            OP_RR: begin
                w_legal = 1'b1; w_rd_we = 1'b1; w_rs1_rd = 1'b1; w_rs2_rd = 1'b1;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        F3_ADD:  w_type = InstAdd;
                        F3_SLL:  w_type = InstSll;
                        F3_SLT:  w_type = InstSlt;
                        F3_SLTU: w_type = InstSltu;
                        F3_XOR:  w_type = InstXor;
                        F3_SR:   w_type = InstSrl;
                        F3_OR:   w_type = InstOr;
                        default: w_type = InstAnd;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
                    w_type = InstSub;
                end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
                    w_type = InstSra;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Unused register fields are zeroed so the bundle only carries meaningful addresses.
    always_comb begin
        ctl_out = '0;
        imm_out = '0;
        if (w_legal) begin
            ctl_out.inst_type = w_type;
            ctl_out.rd_we     = w_rd_we;
            ctl_out.rs1_read  = w_rs1_rd;
            ctl_out.rs2_read  = w_rs2_rd;
            ctl_out.rs1       = w_rs1_rd ? inst_in[RS1_MSB:RS1_LSB] : 5'd0;
            ctl_out.rs2       = w_rs2_rd ? inst_in[RS2_MSB:RS2_LSB] : 5'd0;
            ctl_out.rd        = w_rd_we  ? inst_in[RD_MSB:RD_LSB]   : 5'd0;
            imm_out           = XLEN'($signed(w_imm32));
        end else begin
            ctl_out.illegal = 1'b1;
        end
    end

    assign pc_out = pc_in;
endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between fetch and issue; decodes at enqueue, flushable.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input logic          clk_in,
    input logic          rst_in,
    input logic          flush_in,
    decode_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    dec_ctl_t        w_dec_ctl, w_head;
    logic [XLEN-1:0] w_dec_imm, w_dec_pc;
    dec_ctl_t        r_mem_ctl [DEPTH];
    logic [XLEN-1:0] r_mem_imm [DEPTH];
    logic [XLEN-1:0] r_mem_pc  [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic            r_rdy_en;
    logic            w_in_ready, w_out_valid, w_push, w_pop;

    id_core #(.XLEN(XLEN)) u_id_core (
        .inst_in (bus.inst_in),
        .pc_in   (bus.pc_in),
        .ctl_out (w_dec_ctl),
        .imm_out (w_dec_imm),
        .pc_out  (w_dec_pc)
    );

    // r_rdy_en keeps the fetch side stalled until the first edge after reset release.
    assign w_in_ready  = r_rdy_en && (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid_in && w_in_ready && !flush_in;
    assign w_pop       = w_out_valid && bus.out_ready_in && !flush_in;

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_ctl[r_wptr] <= w_dec_ctl;
            r_mem_imm[r_wptr] <= w_dec_imm;
            r_mem_pc[r_wptr]  <= w_dec_pc;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush_in) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head = r_mem_ctl[r_rptr];

    always_comb begin
        bus.in_ready_out  = w_in_ready;
        bus.out_valid_out = w_out_valid;
        bus.count_out     = r_count;
        bus.illegal_out   = 1'b0;
        bus.inst_type_out = InstNop;
        bus.rd_we_out     = 1'b0;
        bus.rs1_read_out  = 1'b0;
        bus.rs2_read_out  = 1'b0;
        bus.rs1_addr_out  = '0;
        bus.rs2_addr_out  = '0;
        bus.rd_addr_out   = '0;
        bus.imm_out       = '0;
        bus.pc_out        = '0;
        if (w_out_valid) begin
            bus.illegal_out   = w_head.illegal;
            bus.inst_type_out = w_head.inst_type;
            bus.rd_we_out     = w_head.rd_we;
            bus.rs1_read_out  = w_head.rs1_read;
            bus.rs2_read_out  = w_head.rs2_read;
            bus.rs1_addr_out  = w_head.rs1;
            bus.rs2_addr_out  = w_head.rs2;
            bus.rd_addr_out   = w_head.rd;
            bus.imm_out       = r_mem_imm[r_rptr];
            bus.pc_out        = r_mem_pc[r_rptr];
        end
    end
endmodule
